// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time over valid/ready, fixed wait
// states, then a byte/half/word access with a single registered response pulse.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        srst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        ready_q;
  logic        rsp_valid_q;
  logic        rsp_err_q;
  logic [31:0] rsp_rdata_q;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic        accept;
  logic        go_resp;
  logic        cur_we;
  logic [2:0]  cur_f3;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic        f3_bad;
  logic        misal;
  logic        oor;
  logic        err;
  logic [AW-1:0] idx;
  logic [31:0] rd_word;
  logic [31:0] rd_shift;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] ld_data;
  logic [3:0]  be;
  logic [31:0] wlane;
  logic [31:0] wmask;
  logic        wr_en;

  assign accept = req_valid & ready_q;

  // With zero wait states the access happens on the acceptance edge itself,
  // so the live request is used in IDLE and the latched copy otherwise.
  assign go_resp = ((state_q == S_WAIT) && (cnt_q == 4'd1)) ||
                   (accept && (WAIT_STATES == 0));

  always_comb begin
    cur_we    = we_q;
    cur_f3    = f3_q;
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    if (state_q == S_IDLE) begin
      cur_we    = req_we;
      cur_f3    = req_funct3;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
    end
  end

  always_comb begin
    if (cur_we) f3_bad = cur_f3[2] | (cur_f3[1:0] == 2'b11);
    else        f3_bad = (cur_f3[1:0] == 2'b11) | (cur_f3 == 3'b110);
    misal = ((cur_f3[1:0] == 2'b01) & cur_addr[0]) |
            ((cur_f3[1:0] == 2'b10) & (|cur_addr[1:0]));
    oor   = ({2'b00, cur_addr[31:2]} >= DEPTH_WORDS);
    err   = f3_bad | misal | oor;
  end

  assign idx      = cur_addr[AW+1:2];
  assign rd_word  = mem_q[idx];
  assign rd_shift = rd_word >> {cur_addr[1:0], 3'b000};
  assign rd_byte  = rd_shift[7:0];
  assign rd_half  = cur_addr[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    ld_data = '0;
    case (cur_f3)
      3'b000:  ld_data = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  ld_data = {{16{rd_half[15]}}, rd_half};
      3'b010:  ld_data = rd_word;
      3'b100:  ld_data = {24'b0, rd_byte};
      3'b101:  ld_data = {16'b0, rd_half};
      default: ld_data = '0;
    endcase
  end

  always_comb begin
    be    = 4'hF;
    wlane = cur_wdata;
    case (cur_f3[1:0])
      2'b00: begin
        be    = 4'b0001 << cur_addr[1:0];
        wlane = {4{cur_wdata[7:0]}};
      end
      2'b01: begin
        be    = cur_addr[1] ? 4'b1100 : 4'b0011;
        wlane = {2{cur_wdata[15:0]}};
      end
      default: begin
        be    = 4'hF;
        wlane = cur_wdata;
      end
    endcase
    wmask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  end

  assign wr_en = go_resp & cur_we & ~err & ~srst;

  // Backing array is deliberately outside reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[idx] <= (rd_word & ~wmask) | (wlane & wmask);
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= go_resp;
      rsp_err_q   <= go_resp & err;
      rsp_rdata_q <= (go_resp && !cur_we && !err) ? ld_data : '0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cnt_q   <= 4'(WAIT_STATES);
            ready_q <= 1'b0;
            state_q <= (WAIT_STATES == 0) ? S_RESP : S_WAIT;
          end else begin
            ready_q <= 1'b1;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= S_RESP;
        end
        S_RESP: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus random traffic checked
// against a byte-addressed memory model.
module tb_dmem_responder;

  localparam int unsigned TB_DEPTH = 256;
  localparam int unsigned TB_WS    = 2;

  logic        clk = 1'b0;
  logic        srst;

  logic        v2, rdy2, we2, rv2, er2;
  logic [2:0]  f32;
  logic [31:0] a2, wd2, rd2;

  logic        v0, rdy0, we0, rv0, er0;
  logic [2:0]  f30;
  logic [31:0] a0, wd0, rd0;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] mem_b [4*TB_DEPTH];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(TB_DEPTH), .WAIT_STATES(TB_WS)) u_dut (
    .clk(clk), .srst(srst), .req_valid(v2), .req_ready(rdy2), .req_we(we2),
    .req_funct3(f32), .req_addr(a2), .req_wdata(wd2), .rsp_valid(rv2),
    .rsp_rdata(rd2), .rsp_err(er2)
  );

  dmem_responder #(.DEPTH_WORDS(16), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .srst(srst), .req_valid(v0), .req_ready(rdy0), .req_we(we0),
    .req_funct3(f30), .req_addr(a0), .req_wdata(wd0), .rsp_valid(rv0),
    .rsp_rdata(rd0), .rsp_err(er0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, output logic [31:0] rd, output logic err);
    int unsigned sz;
    logic        legal;
    logic [31:0] v;
    sz    = 1 << f3[1:0];
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    err   = !legal || ((a % sz) != 0) || ((a / 4) >= TB_DEPTH);
    rd    = '0;
    if (!err) begin
      if (we) begin
        for (int unsigned i = 0; i < sz; i++) mem_b[a + i] = 8'(wd >> (8 * i));
      end else begin
        v = '0;
        for (int unsigned i = 0; i < sz; i++) v |= 32'(mem_b[a + i]) << (8 * i);
        if (!f3[2] && sz < 4 && v[8 * sz - 1]) v |= 32'hFFFF_FFFF << (8 * sz);
        rd = v;
      end
    end
  endfunction

  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] od, output logic oe);
    logic [31:0] exp_d;
    logic        exp_e;
    int          n;
    int          lat;
    model(we, f3, a, wd, exp_d, exp_e);
    @(negedge clk);
    v2 = 1'b1; we2 = we; f32 = f3; a2 = a; wd2 = wd;
    n = 0;
    while (rdy2 !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_timeout", 32'(n < 20), 32'd1);
    @(negedge clk);
    v2 = 1'b0;
    lat = 1;
    while (rv2 !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(TB_WS + 1));
    chk("rsp_err", {31'b0, er2}, {31'b0, exp_e});
    chk("rsp_rdata", rd2, exp_d);
    od = rd2;
    oe = er2;
    @(negedge clk);
    chk("rsp_valid_low", {31'b0, rv2}, 32'd0);
    chk("rdata_idle_zero", rd2, 32'd0);
  endtask

  initial begin
    logic [31:0] od;
    logic        oe;
    int          pulses;
    logic        we_s [4];
    logic [2:0]  f3_s [4];
    logic [31:0] ad_s [4];
    logic [31:0] wd_s [4];
    logic [31:0] ex_s [4];
    int          r;
    logic [31:0] ra;

    srst = 1'b1;
    v2 = 1'b0; we2 = 1'b0; f32 = '0; a2 = '0; wd2 = '0;
    v0 = 1'b0; we0 = 1'b0; f30 = '0; a0 = '0; wd0 = '0;
    repeat (3) @(negedge clk);
    chk("reset_ready", {31'b0, rdy2}, 32'd0);
    chk("reset_rsp_valid", {31'b0, rv2}, 32'd0);
    chk("reset_rdata", rd2, 32'd0);
    chk("reset_err", {31'b0, er2}, 32'd0);
    srst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", {31'b0, rdy2}, 32'd1);
    chk("ready0_after_reset", {31'b0, rdy0}, 32'd1);

    for (int unsigned w = 0; w < TB_DEPTH; w++) run_req(1'b1, 3'b010, 32'(w * 4), $urandom, od, oe);

    run_req(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, od, oe);
    run_req(1'b0, 3'b010, 32'h10, 32'h0, od, oe);
    chk("lw_deadbeef", od, 32'hDEAD_BEEF);

    run_req(1'b1, 3'b010, 32'h10, 32'h1122_3344, od, oe);
    run_req(1'b1, 3'b000, 32'h13, 32'h0000_0080, od, oe);
    run_req(1'b0, 3'b010, 32'h10, 32'h0, od, oe);
    chk("sb_merge", od, 32'h8022_3344);
    run_req(1'b0, 3'b000, 32'h13, 32'h0, od, oe);
    chk("lb_sext", od, 32'hFFFF_FF80);
    run_req(1'b0, 3'b100, 32'h13, 32'h0, od, oe);
    chk("lbu_zext", od, 32'h0000_0080);

    run_req(1'b1, 3'b010, 32'h20, 32'h0, od, oe);
    run_req(1'b1, 3'b001, 32'h22, 32'h0000_8001, od, oe);
    run_req(1'b0, 3'b010, 32'h20, 32'h0, od, oe);
    chk("sh_merge", od, 32'h8001_0000);
    run_req(1'b0, 3'b001, 32'h22, 32'h0, od, oe);
    chk("lh_sext", od, 32'hFFFF_8001);
    run_req(1'b0, 3'b101, 32'h22, 32'h0, od, oe);
    chk("lhu_zext", od, 32'h0000_8001);

    run_req(1'b0, 3'b010, 32'h11, 32'h0, od, oe);
    chk("err_lw_misal", {31'b0, oe}, 32'd1);
    run_req(1'b1, 3'b001, 32'h21, 32'hFFFF_FFFF, od, oe);
    chk("err_sh_misal", {31'b0, oe}, 32'd1);
    run_req(1'b0, 3'b010, 32'(4 * TB_DEPTH), 32'h0, od, oe);
    chk("err_oor", {31'b0, oe}, 32'd1);
    run_req(1'b0, 3'b011, 32'h20, 32'h0, od, oe);
    chk("err_f3", {31'b0, oe}, 32'd1);
    chk("err_f3_rdata", od, 32'd0);
    run_req(1'b0, 3'b010, 32'h20, 32'h0, od, oe);
    chk("after_err_unchanged", od, 32'h8001_0000);

    run_req(1'b1, 3'b010, 32'h40, 32'hA5A5_0F0F, od, oe);
    @(negedge clk);
    v2 = 1'b1; we2 = 1'b1; f32 = 3'b010; a2 = 32'h40; wd2 = 32'h1234_5678;
    @(negedge clk);
    v2 = 1'b0;
    srst = 1'b1;
    @(negedge clk);
    chk("srst_ready", {31'b0, rdy2}, 32'd0);
    chk("srst_rsp_valid", {31'b0, rv2}, 32'd0);
    srst = 1'b0;
    pulses = 0;
    @(negedge clk);
    chk("ready_after_abort", {31'b0, rdy2}, 32'd1);
    repeat (6) begin
      if (rv2 === 1'b1) pulses++;
      @(negedge clk);
    end
    chk("abort_no_rsp", 32'(pulses), 32'd0);
    run_req(1'b0, 3'b010, 32'h40, 32'h0, od, oe);
    chk("abort_no_write", od, 32'hA5A5_0F0F);

    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0) ra = $urandom;
      else        ra = 32'($urandom_range(0, 4 * TB_DEPTH - 1));
      run_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, $urandom, od, oe);
    end

    we_s = '{1'b1, 1'b0, 1'b1, 1'b0};
    f3_s = '{3'b010, 3'b010, 3'b000, 3'b010};
    ad_s = '{32'h8, 32'h8, 32'h9, 32'h8};
    wd_s = '{32'hCAFE_F00D, 32'h0, 32'h0000_005A, 32'h0};
    ex_s = '{32'h0, 32'hCAFE_F00D, 32'h0, 32'hCAFE_5A0D};
    @(negedge clk);
    v0 = 1'b1; we0 = we_s[0]; f30 = f3_s[0]; a0 = ad_s[0]; wd0 = wd_s[0];
    for (int i = 0; i < 4; i++) begin
      chk("b2b_ready_hi", {31'b0, rdy0}, 32'd1);
      chk("b2b_rsp_lo", {31'b0, rv0}, 32'd0);
      @(negedge clk);
      chk("b2b_ready_lo", {31'b0, rdy0}, 32'd0);
      chk("b2b_rsp_hi", {31'b0, rv0}, 32'd1);
      chk("b2b_rdata", rd0, ex_s[i]);
      chk("b2b_err", {31'b0, er0}, 32'd0);
      if (i < 3) begin
        we0 = we_s[i+1]; f30 = f3_s[i+1]; a0 = ad_s[i+1]; wd0 = wd_s[i+1];
      end else begin
        v0 = 1'b0;
      end
      @(negedge clk);
    end
    chk("b2b_idle_rsp", {31'b0, rv0}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
